// File: rtl/pipeline_cp0.sv
// Coprocessor-0 responder for the 5-stage pipeline.
// It executes mtc0/mfc0/eret, takes exceptions and interrupts, and sends a
// one-cycle redirect/flush to the fetch stage.
// Optional feature: define CP0_TIMER_EN to add COUNT (r9) and COMPARE (r11)
// plus the IP7 timer interrupt.
module pipeline_cp0 #(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_0100,
   parameter int          SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  cp_oper,
   input  logic [4:0]  cp_addr,
   input  logic [31:0] cp_wdata,
   output logic [31:0] cp_rdata,
   input  logic [31:0] pc_id,
   input  logic [31:0] pc_ex,
   input  logic        stall,
   input  logic        undefined,
   input  logic        outOfMemory,
   input  logic        ext_int,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic        in_handler
);

   localparam logic [2:0] OP_MTC0 = 3'd1;
   localparam logic [2:0] OP_ERET = 3'd3;

   typedef enum logic [1:0] {RUN, ENTER, RETURN} state_t;

   state_t                 state;
   logic                   ie, exl;
   logic [4:0]             exc_code;
   logic [31:0]            epc, ebase;
   logic [SYNC_STAGES-1:0] sync;
   logic                   ip2, ip7, irq;
   logic                   ev_exc, take_eret, wr_en;
   logic [4:0]             exc_next;
   logic [31:0]            epc_next;

   assign ip2        = sync[SYNC_STAGES-1];
   assign irq        = ip2 | ip7;
   assign in_handler = exl;

   // Two-flop (or deeper) synchronizer for the asynchronous interrupt line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[SYNC_STAGES-2:0], ext_int};
   end

   // Pick the single winning event this cycle (only meaningful in RUN)
   always_comb begin
      ev_exc    = 1'b0;
      exc_next  = 5'd0;
      epc_next  = pc_id;
      take_eret = 1'b0;
      wr_en     = 1'b0;
      if (state == RUN) begin
         if (outOfMemory) begin
            ev_exc   = 1'b1;
            exc_next = 5'd4;
            epc_next = pc_ex;
         end else if (!stall) begin
            if (undefined) begin
               ev_exc   = 1'b1;
               exc_next = 5'd10;
            end else if (irq && ie && !exl) begin
               ev_exc   = 1'b1;
               exc_next = 5'd0;
            end else if (cp_oper == OP_ERET) begin
               take_eret = 1'b1;
            end else if (cp_oper == OP_MTC0) begin
               wr_en = 1'b1;
            end
         end
      end
   end

`ifdef CP0_TIMER_EN
   logic [31:0] count, compare;
   logic        ip7_q;

   // Free-running counter; a COMPARE write acknowledges the timer interrupt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= '0;
         compare <= '0;
         ip7_q   <= 1'b0;
      end else begin
         count <= (wr_en && cp_addr == 5'd9) ? cp_wdata : count + 32'd1;
         if (wr_en && cp_addr == 5'd11) begin
            compare <= cp_wdata;
            ip7_q   <= 1'b0;
         end else if (count == compare && compare != 32'd0) begin
            ip7_q <= 1'b1;
         end
      end
   end
   assign ip7 = ip7_q;
`else
   assign ip7 = 1'b0;
`endif

   // Combinational register read for mfc0 (pre-edge values)
   always_comb begin
      cp_rdata = '0;
      case (cp_addr)
`ifdef CP0_TIMER_EN
         5'd9:  cp_rdata = count;
         5'd11: cp_rdata = compare;
`endif
         5'd12: cp_rdata = {30'd0, exl, ie};
         5'd13: cp_rdata = {16'd0, ip7, 4'd0, ip2, 3'd0, exc_code, 2'd0};
         5'd14: cp_rdata = epc;
         5'd15: cp_rdata = ebase;
         default: cp_rdata = '0;
      endcase
   end

   // Control FSM: register updates and registered redirect/flush outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         ie          <= 1'b0;
         exl         <= 1'b0;
         exc_code    <= '0;
         epc         <= '0;
         ebase       <= HANDLER_ADDR;
         redirect    <= 1'b0;
         flush       <= 1'b0;
         redirect_pc <= '0;
      end else begin
         redirect <= 1'b0;
         flush    <= 1'b0;
         case (state)
            RUN: begin
               if (ev_exc) begin
                  epc         <= epc_next;
                  exc_code    <= exc_next;
                  exl         <= 1'b1;
                  state       <= ENTER;
                  redirect    <= 1'b1;
                  flush       <= 1'b1;
                  redirect_pc <= ebase;
               end else if (take_eret) begin
                  exl         <= 1'b0;
                  state       <= RETURN;
                  redirect    <= 1'b1;
                  flush       <= 1'b1;
                  redirect_pc <= epc;
               end else if (wr_en) begin
                  // CAUSE is entirely read-only from software
                  case (cp_addr)
                     5'd12: {exl, ie} <= cp_wdata[1:0];
                     5'd14: epc       <= cp_wdata;
                     5'd15: ebase     <= cp_wdata;
                     default: ;
                  endcase
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_cp0.sv
// Randomized self-checking bench for pipeline_cp0 with a behavioural model.
module tb_pipeline_cp0;

   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  cp_oper = '0;
   logic [4:0]  cp_addr = '0;
   logic [31:0] cp_wdata = '0;
   logic [31:0] cp_rdata;
   logic [31:0] pc_id = '0;
   logic [31:0] pc_ex = '0;
   logic        stall = 1'b0;
   logic        undefined = 1'b0;
   logic        outOfMemory = 1'b0;
   logic        ext_int = 1'b0;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        flush;
   logic        in_handler;

   pipeline_cp0 #(.HANDLER_ADDR(32'h100), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst_n(rst_n), .cp_oper(cp_oper), .cp_addr(cp_addr),
      .cp_wdata(cp_wdata), .cp_rdata(cp_rdata), .pc_id(pc_id), .pc_ex(pc_ex),
      .stall(stall), .undefined(undefined), .outOfMemory(outOfMemory),
      .ext_int(ext_int), .redirect(redirect), .redirect_pc(redirect_pc),
      .flush(flush), .in_handler(in_handler)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // Reference model: architectural state plus a mode (0 run, 1 enter, 2 return)
   logic        m_ie, m_exl, m_red, m_ip7;
   logic [4:0]  m_exc;
   logic [31:0] m_epc, m_ebase, m_rpc, m_count, m_cmp;
   int          m_mode;
   logic        hist[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      else n_pass++;
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
`ifdef CP0_TIMER_EN
         5'd9:  return m_count;
         5'd11: return m_cmp;
`endif
         5'd12: return {30'd0, m_exl, m_ie};
         5'd13: return (32'(m_ip7) << 15) | (32'(hist[0]) << 10) | (32'(m_exc) << 2);
         5'd14: return m_epc;
         5'd15: return m_ebase;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_ie = 0; m_exl = 0; m_red = 0; m_ip7 = 0; m_exc = 0;
      m_epc = 0; m_ebase = 32'h100; m_rpc = 0; m_count = 0; m_cmp = 0;
      m_mode = 0;
      hist = {};
      repeat (SYNC) hist.push_back(1'b0);
   endtask

   task automatic enter(input logic [31:0] pc, input logic [4:0] code);
      m_epc = pc; m_exc = code; m_exl = 1; m_mode = 1; m_red = 1; m_rpc = m_ebase;
   endtask

   // Advance the model across one rising edge using the current inputs
   task automatic model_edge();
      bit          wr = 0;
      logic        pend = hist[0] | m_ip7;
      logic [31:0] cnt_pre = m_count;
      if (m_mode == 0) begin
         m_red = 0;
         if (outOfMemory) enter(pc_ex, 5'd4);
         else if (!stall && undefined) enter(pc_id, 5'd10);
         else if (!stall && pend && m_ie && !m_exl) enter(pc_id, 5'd0);
         else if (!stall && cp_oper == 3) begin
            m_exl = 0; m_mode = 2; m_red = 1; m_rpc = m_epc;
         end else if (!stall && cp_oper == 1) wr = 1;
      end else begin
         m_mode = 0; m_red = 0;
      end
      if (wr) begin
         if (cp_addr == 12) begin m_exl = cp_wdata[1]; m_ie = cp_wdata[0]; end
         if (cp_addr == 14) m_epc = cp_wdata;
         if (cp_addr == 15) m_ebase = cp_wdata;
      end
`ifdef CP0_TIMER_EN
      if (wr && cp_addr == 11) m_ip7 = 0;
      else if (cnt_pre == m_cmp && m_cmp != 0) m_ip7 = 1;
      if (wr && cp_addr == 11) m_cmp = cp_wdata;
      m_count = (wr && cp_addr == 9) ? cp_wdata : cnt_pre + 1;
`endif
      hist.push_back(ext_int);
      hist.delete(0);
   endtask

   // One clock: check all outputs mid-cycle, then cross the edge
   task automatic step();
      @(negedge clk);
      chk("rdata", cp_rdata, m_read(cp_addr));
      chk("redirect", 32'(redirect), 32'(m_red));
      chk("flush", 32'(flush), 32'(m_red));
      chk("redirect_pc", redirect_pc, m_rpc);
      chk("in_handler", 32'(in_handler), 32'(m_exl));
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cp_oper = 0; undefined = 0; outOfMemory = 0; stall = 0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      cp_oper = 1; cp_addr = a; cp_wdata = d;
      step();
      cp_oper = 0;
   endtask

   initial begin
      int n;
      logic [4:0] addrs [8];
      addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd3};
      do_reset();
      cp_addr = 15; #1;
      chk("rst_ebase", cp_rdata, 32'h100);
      step();

      // mtc0 STATUS then mfc0 STATUS
      mtc0(12, 32'h1);
      cp_oper = 2; cp_addr = 12; #1;
      chk("mfc0_status", cp_rdata, 32'h1);
      step();
      mtc0(13, 32'hFFFF_FFFF);
      cp_oper = 2; cp_addr = 13; #1;
      chk("cause_ro", cp_rdata, 32'h0);
      step(); idle();

      // Reserved instruction
      undefined = 1; pc_id = 32'h40;
      step(); idle();
      chk("undef_red", 32'(redirect), 1);
      chk("undef_rpc", redirect_pc, 32'h100);
      chk("undef_inh", 32'(in_handler), 1);
      cp_addr = 14; #1; chk("undef_epc", cp_rdata, 32'h40);
      cp_addr = 13; #1; chk("undef_cause", cp_rdata, 32'h28);
      step();

      // eret returns to EPC
      cp_oper = 3; step(); idle();
      chk("eret_rpc", redirect_pc, 32'h40);
      chk("eret_exl", 32'(in_handler), 0);
      step();

      // outOfMemory beats undefined
      outOfMemory = 1; undefined = 1; pc_ex = 32'h3C; pc_id = 32'h80;
      step(); idle();
      cp_addr = 14; #1; chk("oom_epc", cp_rdata, 32'h3C);
      cp_addr = 13; #1; chk("oom_cause", cp_rdata, 32'h10);
      step();
      cp_oper = 3; step(); idle(); step();

      // Stalled reserved instruction waits
      undefined = 1; stall = 1;
      repeat (3) step();
      chk("stall_nored", 32'(redirect), 0);
      stall = 0; step(); idle();
      chk("stall_red", 32'(redirect), 1);
      step();
      cp_oper = 3; step(); idle(); step();

      // External interrupt latency with IE=1
      mtc0(12, 32'h1);
      ext_int = 1;
      n = 0;
      while (n < 10 && !redirect) begin step(); n++; end
      chk("irq_latency", 32'(n), 32'(SYNC + 1));
      ext_int = 0;
      repeat (4) step();
      cp_oper = 3; step(); idle();
      chk("irq_eret_rpc", redirect_pc, m_epc);
      step();

      // Interrupt masked by IE=0
      mtc0(12, 32'h0);
      ext_int = 1;
      repeat (8) step();
      chk("masked_nored", 32'(redirect), 0);
      cp_addr = 13; #1; chk("ip2_set", cp_rdata & 32'h400, 32'h400);
      ext_int = 0;
      repeat (4) step();

`ifdef CP0_TIMER_EN
      mtc0(11, 32'd5);
      mtc0(9, 32'd0);
      repeat (7) step();
      cp_addr = 13; #1; chk("ip7_set", cp_rdata & 32'h8000, 32'h8000);
      mtc0(12, 32'h1);
      step();
      cp_addr = 13; #1; chk("timer_exc", cp_rdata & 32'h7C, 32'h0);
      mtc0(11, 32'd0);
      cp_oper = 3; step(); idle(); step();
`endif

      // Reset mid-ENTER aborts the redirect
      undefined = 1; pc_id = 32'h44;
      step(); idle();
      rst_n = 0; #1;
      chk("rst_mid_red", 32'(redirect), 0);
      chk("rst_mid_flush", 32'(flush), 0);
      cp_addr = 15; #1;
      chk("rst_mid_ebase", cp_rdata, 32'h100);
      do_reset();

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         cp_oper     = 3'($urandom_range(0, 5));
         cp_addr     = ($urandom_range(0, 9) == 0) ? 5'($urandom) : addrs[$urandom_range(0, 7)];
         cp_wdata    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         pc_id       = $urandom & 32'hFFFF_FFFC;
         pc_ex       = $urandom & 32'hFFFF_FFFC;
         stall       = ($urandom_range(0, 3) == 0);
         undefined   = ($urandom_range(0, 9) == 0);
         outOfMemory = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 29) == 0) ext_int = ~ext_int;
         if (i == 750) begin
            rst_n = 0; #1;
            chk("rand_rst_red", 32'(redirect), 0);
            do_reset();
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
